// File: rtl/k_update_ctrl.sv
// Coefficient update controller: update_k = sat16(k - ((eta * delta) >>> 10)) in Q6.10,
// sequenced as IDLE -> MUL -> SUB -> DONE with a one-cycle update_coeff strobe.
module k_update_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_init,
    input  logic [15:0] init_k,
    input  logic [15:0] k_in,
    input  logic [15:0] delta,
    input  logic [15:0] eta,
    output logic [15:0] update_k,
    output logic        update_coeff,
    output logic        busy,
    output logic        sat,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [15:0] k_cap;
    logic signed [15:0] delta_cap;
    logic signed [15:0] eta_cap;
    logic signed [31:0] product;

    logic signed [21:0] step;
    logic signed [22:0] diff;
    logic        [15:0] sat_val;
    logic               sat_flag;

    // Handshake: start and load_init are sampled only in IDLE; load_init wins
    // over start, and anything arriving while busy is dropped, never queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !load_init) state_next = MUL;
            MUL:     state_next = SUB;
            SUB:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Dropping the low 10 bits of a two's complement value is a floor shift.
    always_comb begin
        step     = product[31:10];
        diff     = {{7{k_cap[15]}}, k_cap} - {step[21], step};
        sat_val  = diff[15:0];
        sat_flag = 1'b0;
        if (!diff[22] && (diff[21:15] != 7'h00)) begin
            sat_val  = 16'h7FFF;
            sat_flag = 1'b1;
        end else if (diff[22] && (diff[21:15] != 7'h7F)) begin
            sat_val  = 16'h8000;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_cap     <= '0;
            delta_cap <= '0;
            eta_cap   <= '0;
            product   <= '0;
            update_k  <= '0;
            sat       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (load_init) begin
                        update_k <= init_k;
                    end else if (start) begin
                        k_cap     <= k_in;
                        delta_cap <= delta;
                        eta_cap   <= eta;
                        sat       <= 1'b0;
                    end
                end
                MUL: product <= 32'(eta_cap) * 32'(delta_cap);
                SUB: begin
                    update_k <= sat_val;
                    sat      <= sat_flag;
                end
                default: ;
            endcase
        end
    end

    // Decoded straight from the state register so reset clears them at once.
    assign update_coeff = (state == DONE);
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_k_update_ctrl.sv
// Directed bench for k_update_ctrl: expected coefficients are queued when a start is
// driven and popped by a monitor on each update_coeff strobe.
module tb_k_update_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load_init;
    logic [15:0] init_k;
    logic [15:0] k_in;
    logic [15:0] delta;
    logic [15:0] eta;
    logic [15:0] update_k;
    logic        update_coeff;
    logic        busy;
    logic        sat;
    logic [1:0]  dbg_state;

    logic [15:0] exp_q[$];
    logic        exp_sat_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int pulse_count = 0;

    k_update_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .load_init    (load_init),
        .init_k       (init_k),
        .k_in         (k_in),
        .delta        (delta),
        .eta          (eta),
        .update_k     (update_k),
        .update_coeff (update_coeff),
        .busy         (busy),
        .sat          (sat),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {sat, k} for k - floor(eta*delta / 1024), clamped to 16 bits.
    function automatic logic [16:0] model(input logic [15:0] k, input logic [15:0] e,
                                          input logic [15:0] d);
        longint p;
        longint st;
        longint df;
        p  = longint'($signed(e)) * longint'($signed(d));
        st = p >>> 10;
        df = longint'($signed(k)) - st;
        if (df > 32767)       return {1'b1, 16'h7FFF};
        else if (df < -32768) return {1'b1, 16'h8000};
        else                  return {1'b0, 16'(df)};
    endfunction

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && update_coeff) begin
            pulse_count++;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_pulse: observed strobe expected none");
            end
            if (exp_q.size() > 0) begin
                check("sb_update_k", {16'h0, update_k}, {16'h0, exp_q.pop_front()});
                check("sb_sat", {31'h0, sat}, {31'h0, exp_sat_q.pop_front()});
            end
        end
    end

    // Driver: one update with latency, busy, sat-clear and input-isolation checks.
    task automatic do_update(input string tag, input logic [15:0] k, input logic [15:0] e,
                             input logic [15:0] d);
        logic [16:0] m;
        int lat;
        @(negedge clk);
        k_in  = k;
        eta   = e;
        delta = d;
        start = 1'b1;
        m = model(k, e, d);
        exp_q.push_back(m[15:0]);
        exp_sat_q.push_back(m[16]);
        @(posedge clk);
        #1;
        start = 1'b0;
        k_in  = 16'($urandom);
        eta   = 16'($urandom);
        delta = 16'($urandom);
        check({tag, "_busy"}, {31'h0, busy}, 32'd1);
        check({tag, "_sat_clr"}, {31'h0, sat}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (update_coeff) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 32'd2);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {31'h0, busy}, 32'd0);
        check({tag, "_hold"}, {16'h0, update_k}, {16'h0, m[15:0]});
        check({tag, "_sat_sticky"}, {31'h0, sat}, {31'h0, m[16]});
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        start     = 1'b0;
        load_init = 1'b0;
        init_k    = 16'h0;
        k_in      = 16'h0;
        delta     = 16'h0;
        eta       = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_update_k", {16'h0, update_k}, 32'h0);
        check("rst_update_coeff", {31'h0, update_coeff}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_sat", {31'h0, sat}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_update("nominal", 16'h0400, 16'h0200, 16'h0100);
        check("nominal_value", {16'h0, update_k}, 32'h0380);
        do_update("pos_sat", 16'h7C00, 16'h0400, 16'hF000);
        check("pos_sat_value", {16'h0, update_k}, 32'h7FFF);
        check("pos_sat_flag", {31'h0, sat}, 32'd1);
        do_update("neg_sat", 16'h8400, 16'h0400, 16'h1000);
        check("neg_sat_value", {16'h0, update_k}, 32'h8000);
        do_update("floor", 16'h0000, 16'h0001, 16'hFFFF);
        check("floor_value", {16'h0, update_k}, 32'h0001);
        for (int i = 0; i < 4; i++) begin
            do_update("rand", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      16'($urandom_range(0, 65535)));
        end

        // start held high for 8 edges: accepted on the 1st and 5th only
        base = pulse_count;
        @(negedge clk);
        k_in  = 16'h0100;
        eta   = 16'h0100;
        delta = 16'h0100;
        start = 1'b1;
        exp_q.push_back(16'h00C0);
        exp_sat_q.push_back(1'b0);
        exp_q.push_back(16'h00C0);
        exp_sat_q.push_back(1'b0);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("burst_pulses", pulse_count - base, 32'd2);
        check("burst_queue_empty", exp_q.size(), 32'd0);

        // load_init beats a simultaneous start
        base = pulse_count;
        @(negedge clk);
        init_k    = 16'h1234;
        load_init = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        load_init = 1'b0;
        start     = 1'b0;
        check("load_value", {16'h0, update_k}, 32'h1234);
        check("load_busy", {31'h0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("load_no_pulse", pulse_count - base, 32'd0);
        check("load_hold", {16'h0, update_k}, 32'h1234);

        // load_init while busy is ignored
        @(negedge clk);
        k_in  = 16'h0800;
        eta   = 16'h0400;
        delta = 16'h0080;
        start = 1'b1;
        exp_q.push_back(16'h0780);
        exp_sat_q.push_back(1'b0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        init_k    = 16'h5555;
        load_init = 1'b1;
        @(posedge clk);
        #1;
        load_init = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_load_value", {16'h0, update_k}, 32'h0780);
        check("busy_load_queue", exp_q.size(), 32'd0);

        // reset in SUB aborts the update
        base = pulse_count;
        @(negedge clk);
        k_in  = 16'h0400;
        eta   = 16'h0200;
        delta = 16'h0100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_sub", {30'h0, dbg_state}, 32'd2);
        rst = 1'b1;
        #1;
        check("abort_update_k", {16'h0, update_k}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_coeff", {31'h0, update_coeff}, 32'd0);
        check("abort_sat", {31'h0, sat}, 32'd0);
        check("abort_state", {30'h0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_pulse", pulse_count - base, 32'd0);

        do_update("post_reset", 16'h0400, 16'h0200, 16'h0100);
        check("post_reset_value", {16'h0, update_k}, 32'h0380);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/k_update_ctrl.md
K_UPDATE_CTRL -- requirements
Module: k_update_ctrl

Interface
REQ-001 The block SHALL use fixed-point format Q6.10 signed, 16 bits (pattern 00_0000.0000_0000_00), for all k, delta and eta values.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  single-cycle request to compute one coefficient update.
REQ-005 load_init  input  1  loads init_k into update_k.
REQ-006 init_k  input  16  signed initial coefficient value.
REQ-007 k_in  input  16  signed current coefficient, as selected downstream.
REQ-008 delta  input  16  signed back-propagated error term.
REQ-009 eta  input  16  signed learning rate.
REQ-010 update_k  output  16  signed registered new coefficient, driven to the k selector.
REQ-011 update_coeff  output  1  one-cycle strobe: update_k is valid and SHALL be selected.
REQ-012 busy  output  1  high while an update is in progress.
REQ-013 sat  output  1  saturation occurred in the most recent update; sticky until the next start.

Function
REQ-014 FSM states SHALL be IDLE, MUL, SUB, DONE; reset state SHALL be IDLE.
REQ-015 In IDLE with start=1 and load_init=0, the block SHALL capture k_in, delta and eta, clear sat, and go to MUL.
REQ-016 In MUL, the block SHALL register the full 32-bit signed product eta*delta and go to SUB.
REQ-017 In SUB, the block SHALL compute step = product arithmetically shifted right by 10 (floor, no rounding; 22-bit signed).
REQ-018 In SUB, the block SHALL compute diff = k_cap - step at 23 bits or more, and go to DONE.
REQ-019 diff SHALL saturate into update_k: >32767 gives 0x7FFF with sat=1; <-32768 gives 0x8000 with sat=1; otherwise the low 16 bits with sat=0.
REQ-020 In DONE, update_coeff SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE.
REQ-021 Latency: start sampled at edge N, update_k valid after edge N+2, update_coeff high between edges N+2 and N+3.
REQ-022 busy SHALL be 1 in MUL, SUB and DONE, and 0 in IDLE.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-024 In IDLE, load_init=1 SHALL set update_k to init_k at the next edge without an update_coeff pulse.
REQ-025 load_init SHALL take priority over a simultaneous start, and that start SHALL be dropped.
REQ-026 load_init while busy=1 SHALL be ignored.
REQ-027 update_k SHALL hold its value in every state except SUB and an accepted load_init.
REQ-028 Captured inputs SHALL be used for the whole update; input changes after capture SHALL have no effect.

Reset
REQ-029 On rst=1, the block SHALL immediately set state to IDLE, update_k=0x0000, update_coeff=0, busy=0 and sat=0, regardless of clock.
REQ-030 Reset asserted mid-operation (MUL, SUB or DONE) SHALL abort the update with no update_coeff pulse after release.
REQ-031 The first start after reset release SHALL be accepted normally.

Verification
REQ-032 Nominal: k_in=0x0400, eta=0x0200, delta=0x0100, start -> update_k=0x0380, sat=0, update_coeff pulse 3 cycles after start.
REQ-033 Positive saturation: k_in=0x7C00, eta=0x0400, delta=0xF000 -> update_k=0x7FFF, sat=1.
REQ-034 Negative saturation: k_in=0x8400, eta=0x0400, delta=0x1000 -> update_k=0x8000, sat=1.
REQ-035 Floor shift: k_in=0x0000, eta=0x0001, delta=0xFFFF -> product -1, step -1, update_k=0x0001.
REQ-036 Control: start every cycle for 8 cycles -> exactly 2 update_coeff pulses; rst during SUB -> outputs zero and no pulse.
REQ-037 Control: load_init together with start in IDLE (init_k=0x1234) -> update_k=0x1234, busy stays 0, no pulse.
